// File: rtl/fetch_pkg.sv
// Shared widths, sizes and the queue entry type for the prefetching fetch unit.
package fetch_pkg;
    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int DEPTH       = 4;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CNT_W       = $clog2(DEPTH + 1);
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer of fetch entries with push, pop and single-cycle flush.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] pushData,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] headData,
    output logic [CNT_W-1:0]   count
);
    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPop;

    // popping an empty queue is a no-op
    assign doPop    = pop && (count != '0);
    assign headData = mem[rdPtr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !doPop) begin
                count <= count + 1'b1;
            end else if (!push && doPop) begin
                count <= count - 1'b1;
            end
        end
    end

    // the issue credit rule guarantees a slot for every response
    noOverflow: assert property (@(posedge clock) disable iff (!reset)
        (push && !flush) |-> (count < CNT_W'(DEPTH)));
endmodule

// File: rtl/instr_fetch_unit.sv
// Prefetching fetch unit: credit-limited issue, in-order response tagging and redirect with stale-response dropping.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
)
(
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [ILEN-1:0]  imem_rdata,
    output logic             ir_valid,
    input  logic             ir_ready,
    output logic [ILEN-1:0]  ir_instr,
    output logic [XLEN-1:0]  ir_pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             misalign_err,
    output logic [CNT_W-1:0] q_count
);
    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] respPc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] dropCnt;
    logic [CNT_W:0]   used;
    logic             issue;
    logic             push;
    logic             pop;
    logic             dropResp;
    logic [XLEN-1:0]  redirectBase;
    fetch_entry_t     headEntry;
    fetch_entry_t     pushEntry;

    assign used      = {1'b0, q_count} + {1'b0, inflight};
    assign imem_req  = reset && !redirect_valid && (used < (CNT_W+1)'(DEPTH));
    assign imem_addr = fetchPc;
    assign issue     = imem_req && imem_gnt;
    assign dropResp  = (dropCnt != '0);
    assign push      = imem_rvalid && !dropResp && !redirect_valid;
    assign pop       = ir_valid && ir_ready;

    assign redirectBase = {redirect_pc[XLEN-1:2], 2'b00};
    assign pushEntry    = '{pc: respPc, instr: imem_rdata};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetchPc      <= RESET_PC;
            respPc       <= RESET_PC;
            inflight     <= '0;
            dropCnt      <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (issue && !imem_rvalid) begin
                inflight <= inflight + 1'b1;
            end else if (!issue && imem_rvalid) begin
                inflight <= inflight - 1'b1;
            end
            if (redirect_valid) begin
                fetchPc <= redirectBase;
                respPc  <= redirectBase;
                // every fetch still outstanding after this cycle belongs to the old stream
                dropCnt <= inflight - {{(CNT_W-1){1'b0}}, imem_rvalid};
            end else begin
                if (issue) begin
                    fetchPc <= fetchPc + XLEN'(INSTR_BYTES);
                end
                if (push) begin
                    respPc <= respPc + XLEN'(INSTR_BYTES);
                end
                if (imem_rvalid && dropResp) begin
                    dropCnt <= dropCnt - 1'b1;
                end
            end
        end
    end

    fetch_fifo uFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pushData (pushEntry),
        .pop      (pop),
        .flush    (redirect_valid),
        .headData (headEntry),
        .count    (q_count)
    );

    assign ir_valid = (q_count != '0);
    assign ir_instr = headEntry.instr;
    assign ir_pc    = headEntry.pc;
endmodule
